pulse_measure: RTL and testbench
================================

Name: pulse_measure

Overview:
- Sits directly downstream of the shake elimination filter and consumes its debounced output.
- Measures, in clk_i cycles, the high time, low time and period of the filtered signal. Each completed cycle, delimited by rising edge to rising edge, is presented as one result.
- Results are held under a valid/ack handshake for the control/register layer. Overrun and timeout status is reported alongside.

Parameters:
- CNT_W, 24, width of all cycle counters and result fields (minimum 4).
- TMO_W, 16, width of the timeout threshold input.

Ports:
- clk_i  input  1  block clock; same clock as the upstream filter.
- rst_i  input  1  reset; synchronous, active-high.
- sig_i  input  1  filtered signal; already synchronous to clk_i, no internal synchroniser.
- timeout_i  input  TMO_W  maximum cycles allowed at one level; 0 = timeout disabled.
- ack_i  input  1  consumer acknowledge; clears valid_o.
- high_o  output  CNT_W  high time of last completed cycle.
- low_o  output  CNT_W  low time of last completed cycle.
- period_o  output  CNT_W  high_o + low_o, saturated.
- valid_o  output  1  result pending.
- overrun_o  output  1  sticky; a result was overwritten while still pending.
- timeout_o  output  1  signal stuck at one level longer than timeout_i.

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - Clears all outputs, counters and the edge register (sig_d <= 0).
  - State <= SYNC.
  - Reset mid-measurement discards the partial cycle; no result is produced.
- Edge detection:
  - rise = sig_i & ~sig_d; fall = ~sig_i & sig_d; sig_d is sig_i registered every cycle.
- Level counter cnt (CNT_W):
  - Loaded with 1 on any edge cycle.
  - Otherwise incremented each cycle, saturating at all-ones (no wrap).
- Width convention:
  - Signal sampled high for exactly H consecutive edges gives captured high = H; same for low.
- States:
  - SYNC: wait for first rise, ignoring falls. On rise -> HIGH. No result is produced for the partial cycle after reset or timeout.
  - HIGH: on fall, capture high_tmp <= cnt -> LOW.
  - LOW: on rise, capture the result -> HIGH.
  - STUCK: entered from HIGH or LOW when timeout_i != 0 and cnt >= timeout_i at a non-edge cycle. Sets timeout_o <= 1. On the next rise: clear timeout_o and -> HIGH. Falls in STUCK are ignored.
- Result capture (in LOW, on rise), registered:
  - high_o <= high_tmp.
  - low_o <= cnt.
  - period_o <= high_tmp + cnt, computed CNT_W+1 wide and saturated to all-ones on carry.
  - valid_o <= 1 in the cycle after the rise is sampled; latency is 1 clock.
- Handshake:
  - valid_o stays high and result fields stay stable until ack_i=1 at a clock edge, which clears valid_o next cycle.
  - ack_i while valid_o=0 is ignored.
  - If a new capture and ack_i coincide: the capture wins, valid_o stays 1 with new data, and overrun_o is not set.
  - If a new capture occurs while valid_o=1 and ack_i=0: fields are overwritten and overrun_o <= 1.
- overrun_o is sticky; only rst_i clears it.
- Timeout boundaries:
  - An edge arriving in the same cycle cnt reaches timeout_i takes priority; no timeout.
  - Changing timeout_i at runtime takes effect on the next compare.

Optional Feature:
- Macro: PULSE_MEASURE_EDGE_CNT_EN.
- Defined:
  - Adds output rise_cnt_o [15:0], a free-running count of rising edges detected in any state, including SYNC and STUCK.
  - Wraps 16'hFFFF -> 0; cleared by rst_i.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset then square wave high 5 / low 3 cycles, repeated. First result after the second rise: high_o=5, low_o=3, period_o=8, valid_o exactly 1 cycle after rise sampled.
- Hold ack_i=0 across two completed cycles (6/2 then 4/4). Result fields show 4/4/8, valid_o=1, overrun_o=1. Then ack_i=1 one cycle: valid_o=0, overrun_o stays 1.
- ack_i asserted in the same cycle as a new capture. valid_o remains 1 with new data, overrun_o=0.
- timeout_i=10, sig_i held high 20 cycles after a rise. timeout_o=1 from cnt=10 onward, no result. Then 3 low / 3 high / rise: timeout_o clears on the first rise, next result high=3, low=3.
- CNT_W=4, high 12 / low 10. high_o=12, low_o=10, period_o=15 (saturated). Separately, high 20 gives high_o=15.
- rst_i pulsed mid-HIGH. All outputs 0, no result until two further rises.
- With PULSE_MEASURE_EDGE_CNT_EN: 3 rises gives rise_cnt_o=3.

Source files
------------

// File: rtl/pulse_measure.sv
`default_nettype none
// ============================================================================
// Module      : pulse_measure
// Description : Measures high time, low time and period (in clk_i cycles) of
//               the debounced signal, one result per rise-to-rise cycle, held
//               under a valid/ack handshake with overrun and timeout status.
//               Optional rise counter enabled by PULSE_MEASURE_EDGE_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_measure #(
    parameter int CNT_W = 24,
    parameter int TMO_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             sig_i,
    input  logic [TMO_W-1:0] timeout_i,
    input  logic             ack_i,
    output logic [CNT_W-1:0] high_o,
    output logic [CNT_W-1:0] low_o,
    output logic [CNT_W-1:0] period_o,
    output logic             valid_o,
    output logic             overrun_o,
    output logic             timeout_o
`ifdef PULSE_MEASURE_EDGE_CNT_EN
    ,
    output logic [15:0]      rise_cnt_o
`endif
);

    localparam int              CMP_W     = (CNT_W > TMO_W) ? CNT_W : TMO_W;
    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        HIGH  = 2'd1,
        LOW   = 2'd2,
        STUCK = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic             r_sig_d;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_high_tmp;
    logic [CNT_W-1:0] r_high;
    logic [CNT_W-1:0] r_low;
    logic [CNT_W-1:0] r_period;
    logic             r_valid;
    logic             r_overrun;
    logic             r_timeout;

    logic             w_rise;
    logic             w_fall;
    logic             w_edge;
    logic [CMP_W-1:0] w_cnt_ext;
    logic [CMP_W-1:0] w_tmo_ext;
    logic             w_tmo_hit;
    logic [CNT_W:0]   w_sum;
    logic [CNT_W-1:0] w_period_sat;

    logic             w_capture;
    logic             w_latch_high;
    logic             w_enter_stuck;
    logic             w_leave_stuck;

    assign w_rise = sig_i & ~r_sig_d;
    assign w_fall = ~sig_i & r_sig_d;
    assign w_edge = w_rise | w_fall;

    // Compare at the wider of the two widths so neither operand is truncated.
    assign w_cnt_ext = CMP_W'(r_cnt);
    assign w_tmo_ext = CMP_W'(timeout_i);
    assign w_tmo_hit = (timeout_i != '0) && (w_cnt_ext >= w_tmo_ext) && !w_edge;

    assign w_sum        = {1'b0, r_high_tmp} + {1'b0, r_cnt};
    assign w_period_sat = w_sum[CNT_W] ? C_CNT_MAX : w_sum[CNT_W-1:0];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= SYNC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_capture     = 1'b0;
        w_latch_high  = 1'b0;
        w_enter_stuck = 1'b0;
        w_leave_stuck = 1'b0;
        case (r_state)
            SYNC: begin
                if (w_rise) begin
                    w_state_nxt = HIGH;
                end
            end
            HIGH: begin
                if (w_fall) begin
                    w_latch_high = 1'b1;
                    w_state_nxt  = LOW;
                end else if (w_tmo_hit) begin
                    w_enter_stuck = 1'b1;
                    w_state_nxt   = STUCK;
                end
            end
            LOW: begin
                if (w_rise) begin
                    w_capture   = 1'b1;
                    w_state_nxt = HIGH;
                end else if (w_tmo_hit) begin
                    w_enter_stuck = 1'b1;
                    w_state_nxt   = STUCK;
                end
            end
            STUCK: begin
                if (w_rise) begin
                    w_leave_stuck = 1'b1;
                    w_state_nxt   = HIGH;
                end
            end
            default: begin
                w_state_nxt = SYNC;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sig_d    <= 1'b0;
            r_cnt      <= '0;
            r_high_tmp <= '0;
            r_high     <= '0;
            r_low      <= '0;
            r_period   <= '0;
            r_valid    <= 1'b0;
            r_overrun  <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_sig_d <= sig_i;

            // Level counter restarts at 1 so a level held for N samples reads N.
            if (w_edge) begin
                r_cnt <= C_CNT_ONE;
            end else if (r_cnt != C_CNT_MAX) begin
                r_cnt <= r_cnt + C_CNT_ONE;
            end

            if (w_latch_high) begin
                r_high_tmp <= r_cnt;
            end

            if (w_enter_stuck) begin
                r_timeout <= 1'b1;
            end else if (w_leave_stuck) begin
                r_timeout <= 1'b0;
            end

            // A fresh capture overrides a coincident ack.
            if (w_capture) begin
                r_high   <= r_high_tmp;
                r_low    <= r_cnt;
                r_period <= w_period_sat;
                r_valid  <= 1'b1;
                if (r_valid && !ack_i) begin
                    r_overrun <= 1'b1;
                end
            end else if (ack_i) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign high_o    = r_high;
    assign low_o     = r_low;
    assign period_o  = r_period;
    assign valid_o   = r_valid;
    assign overrun_o = r_overrun;
    assign timeout_o = r_timeout;

`ifdef PULSE_MEASURE_EDGE_CNT_EN
    logic [15:0] r_rise_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rise_cnt <= '0;
        end else if (w_rise) begin
            r_rise_cnt <= r_rise_cnt + 16'd1;
        end
    end

    assign rise_cnt_o = r_rise_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pulse_measure.sv
`default_nettype none
// ============================================================================
// Module      : tb_pulse_measure
// Description : Self-checking bench for pulse_measure at CNT_W=24 and CNT_W=4,
//               directed scenarios plus randomized runs against a run-length
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_measure;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sig = 1'b0;
    logic        ack = 1'b0;
    logic [15:0] tmo = 16'd0;

    logic [23:0] high_a, low_a, period_a;
    logic        valid_a, ovr_a, tmo_a;
    logic [3:0]  high_b, low_b, period_b;
    logic        valid_b, ovr_b, tmo_b;
`ifdef PULSE_MEASURE_EDGE_CNT_EN
    logic [15:0] rc_a, rc_b;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    bit g_rand_ack = 1'b0;

    always #5 clk = ~clk;

    pulse_measure #(.CNT_W(24), .TMO_W(16)) u_dut_a (
        .clk_i(clk), .rst_i(rst), .sig_i(sig), .timeout_i(tmo), .ack_i(ack),
        .high_o(high_a), .low_o(low_a), .period_o(period_a),
        .valid_o(valid_a), .overrun_o(ovr_a), .timeout_o(tmo_a)
`ifdef PULSE_MEASURE_EDGE_CNT_EN
        , .rise_cnt_o(rc_a)
`endif
    );

    pulse_measure #(.CNT_W(4), .TMO_W(16)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .sig_i(sig), .timeout_i(tmo), .ack_i(ack),
        .high_o(high_b), .low_o(low_b), .period_o(period_b),
        .valid_o(valid_b), .overrun_o(ovr_b), .timeout_o(tmo_b)
`ifdef PULSE_MEASURE_EDGE_CNT_EN
        , .rise_cnt_o(rc_b)
`endif
    );

    // Reference model: tracks run lengths of the sampled signal and whether the
    // current run follows a measured high phase, for each counter width.
    localparam int PH_SYNC = 0, PH_HIGH = 1, PH_LOW = 2, PH_STUCK = 3;
    int maxv [2] = '{16777215, 15};
    int m_phase [2], m_h [2], m_high [2], m_low [2], m_per [2];
    int m_valid [2], m_ovr [2], m_tmo [2];
    int m_len;
    int m_rc;
    bit m_prev;

    function automatic int sat(input int x, input int mx);
        return (x > mx) ? mx : x;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_phase[i] = PH_SYNC; m_h[i] = 0; m_high[i] = 0; m_low[i] = 0;
            m_per[i] = 0; m_valid[i] = 0; m_ovr[i] = 0; m_tmo[i] = 0;
        end
        m_len = 0; m_rc = 0; m_prev = 1'b0;
    endtask

    task automatic model_step(input bit s, input bit a, input int t, input bit r);
        bit edge_s, cap;
        int l;
        if (r) begin
            model_reset();
            return;
        end
        edge_s = (s != m_prev);
        for (int i = 0; i < 2; i++) begin
            cap = 1'b0;
            l   = sat(m_len, maxv[i]);
            if (edge_s && s) begin
                if (m_phase[i] == PH_LOW) cap = 1'b1;
                m_phase[i] = PH_HIGH;
                m_tmo[i]   = 0;
            end else if (edge_s && !s) begin
                if (m_phase[i] == PH_HIGH) begin
                    m_h[i]     = l;
                    m_phase[i] = PH_LOW;
                end
            end else if ((m_phase[i] == PH_HIGH || m_phase[i] == PH_LOW) && t != 0 && l >= t) begin
                m_phase[i] = PH_STUCK;
                m_tmo[i]   = 1;
            end
            if (cap) begin
                if (m_valid[i] != 0 && !a) m_ovr[i] = 1;
                m_valid[i] = 1;
                m_high[i]  = m_h[i];
                m_low[i]   = l;
                m_per[i]   = sat(m_h[i] + l, maxv[i]);
            end else if (a) begin
                m_valid[i] = 0;
            end
        end
        if (edge_s && s) m_rc = (m_rc + 1) & 16'hFFFF;
        if (edge_s) m_len = 1;
        else if (m_len < 32'h3FFF_FFFF) m_len = m_len + 1;
        m_prev = s;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    task automatic compare_all();
        check("a_high",   32'(high_a),   32'(m_high[0]));
        check("a_low",    32'(low_a),    32'(m_low[0]));
        check("a_period", 32'(period_a), 32'(m_per[0]));
        check("a_valid",  32'(valid_a),  32'(m_valid[0]));
        check("a_ovr",    32'(ovr_a),    32'(m_ovr[0]));
        check("a_tmo",    32'(tmo_a),    32'(m_tmo[0]));
        check("b_high",   32'(high_b),   32'(m_high[1]));
        check("b_low",    32'(low_b),    32'(m_low[1]));
        check("b_period", 32'(period_b), 32'(m_per[1]));
        check("b_valid",  32'(valid_b),  32'(m_valid[1]));
        check("b_ovr",    32'(ovr_b),    32'(m_ovr[1]));
        check("b_tmo",    32'(tmo_b),    32'(m_tmo[1]));
`ifdef PULSE_MEASURE_EDGE_CNT_EN
        check("a_rc",     32'(rc_a),     32'(m_rc));
        check("b_rc",     32'(rc_b),     32'(m_rc));
`endif
    endtask

    // Called at a negedge; drives inputs, lets one edge pass, checks at next negedge.
    task automatic step(input logic s, input logic a, input logic r);
        sig = s; ack = a; rst = r;
        @(posedge clk);
        model_step(s, a, int'(tmo), r);
        @(negedge clk);
        cyc++;
        compare_all();
    endtask

    task automatic run(input logic lvl, input int len, input logic ack_first);
        logic a;
        for (int i = 0; i < len; i++) begin
            if (i == 0) a = ack_first;
            else a = g_rand_ack ? ($urandom_range(0, 3) == 0) : 1'b0;
            step(lvl, a, 1'b0);
        end
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();
        check("rst_valid",  32'(valid_a), 32'd0);
        check("rst_high",   32'(high_a),  32'd0);

        // Square wave 5 high / 3 low
        run(0, 2, 0); run(1, 5, 0); run(0, 3, 0);
        check("sq_valid_pre", 32'(valid_a), 32'd0);
        run(1, 1, 0);
        check("sq_high",   32'(high_a),   32'd5);
        check("sq_low",    32'(low_a),    32'd3);
        check("sq_period", 32'(period_a), 32'd8);
        check("sq_valid",  32'(valid_a),  32'd1);

        // Overrun across two unacknowledged results
        run(1, 4, 1); run(0, 3, 0); run(1, 6, 0); run(0, 2, 0); run(1, 4, 0);
        run(0, 4, 0); run(1, 1, 0);
        check("ovr_high",   32'(high_a),   32'd4);
        check("ovr_low",    32'(low_a),    32'd4);
        check("ovr_period", 32'(period_a), 32'd8);
        check("ovr_flag",   32'(ovr_a),    32'd1);
        run(1, 2, 1);
        check("ovr_valid_ack", 32'(valid_a), 32'd0);
        check("ovr_sticky",    32'(ovr_a),   32'd1);

        // Ack coincident with a new capture
        do_reset();
        run(0, 2, 0); run(1, 3, 0); run(0, 2, 0); run(1, 1, 0);
        run(1, 2, 0); run(0, 3, 0); run(1, 1, 1);
        check("coin_valid", 32'(valid_a), 32'd1);
        check("coin_low",   32'(low_a),   32'd3);
        check("coin_ovr",   32'(ovr_a),   32'd0);

        // Timeout
        tmo = 16'd10;
        do_reset();
        run(0, 1, 0); run(1, 20, 0);
        check("tmo_set",   32'(tmo_a),   32'd1);
        check("tmo_noval", 32'(valid_a), 32'd0);
        run(0, 3, 0); run(1, 3, 0);
        check("tmo_clear", 32'(tmo_a), 32'd0);
        run(0, 3, 0); run(1, 1, 0);
        check("tmo_res_high", 32'(high_a), 32'd3);
        check("tmo_res_low",  32'(low_a),  32'd3);
        run(1, 9, 0); run(0, 10, 0); run(1, 1, 0);
        check("tmo_edge_prio", 32'(tmo_a),  32'd0);
        check("tmo_edge_high", 32'(high_a), 32'd10);
        check("tmo_edge_low",  32'(low_a),  32'd10);

        // Saturation on the narrow instance
        tmo = 16'd0;
        do_reset();
        run(0, 1, 0); run(1, 12, 0); run(0, 10, 0); run(1, 1, 0);
        check("sat_b_high",   32'(high_b),   32'd12);
        check("sat_b_low",    32'(low_b),    32'd10);
        check("sat_b_period", 32'(period_b), 32'd15);
        check("sat_a_period", 32'(period_a), 32'd22);
        run(1, 19, 0); run(0, 2, 0); run(1, 1, 0);
        check("sat_b_high20", 32'(high_b), 32'd15);
        check("sat_a_high20", 32'(high_a), 32'd20);

        // Reset in the middle of a high phase
        run(0, 2, 0); run(1, 3, 0);
        step(1'b1, 1'b0, 1'b1);
        check("mid_rst_high",  32'(high_a),  32'd0);
        check("mid_rst_valid", 32'(valid_a), 32'd0);
        check("mid_rst_ovr",   32'(ovr_a),   32'd0);
        run(1, 2, 0); run(0, 2, 0);
        check("mid_rst_nores", 32'(valid_a), 32'd0);
        run(1, 1, 0);
        check("mid_rst_res",   32'(high_a),  32'd2);

`ifdef PULSE_MEASURE_EDGE_CNT_EN
        do_reset();
        run(0, 1, 0); run(1, 2, 0); run(0, 2, 0); run(1, 2, 0); run(0, 2, 0); run(1, 1, 0);
        check("rise_cnt3", 32'(rc_a), 32'd3);
`endif

        // Randomized runs
        g_rand_ack = 1'b1;
        begin
            logic lvl;
            lvl = 1'b0;
            for (int n = 0; n < 400; n++) begin
                if ($urandom_range(0, 19) == 0)
                    tmo = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(3, 12));
                if ($urandom_range(0, 49) == 0) step(lvl, 1'b0, 1'b1);
                run(lvl, int'($urandom_range(1, 14)), 1'($urandom_range(0, 3) == 0));
                lvl = ~lvl;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
